// File: rtl/sdhost_cmd.sv
`timescale 1ns/1ps
// sdhost_cmd: host-side SD command-wire engine.
// Serializes 48-bit commands onto CMD with CRC7 and captures 48-bit or
// 136-bit responses. It checks the response CRC7 and end bit, applies the
// NCR response timeout, and holds an NCC idle gap after each transaction.
// All wire activity advances only on the i_ce SD-clock tick strobe.
// Ports:
//   i_clk, i_reset_n                 clock, async active-low reset
//   i_ce                             SD-clock tick strobe
//   i_cmd_valid/o_cmd_ready          command handshake (ready == IDLE)
//   i_rsp_type, i_cmd, i_arg         request: response type, index, argument
//   o_cmd_en, o_cmd_out, i_cmd_in    CMD pad enable / data out / data in
//   o_rsp_valid                      one-cycle completion pulse
//   o_rsp_status/index/data          completion result, held until next pulse
module sdhost_cmd #(
    parameter int unsigned NCR = 64,
    parameter int unsigned NCC = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_ce,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [1:0]   i_rsp_type,
    input  logic [5:0]   i_cmd,
    input  logic [31:0]  i_arg,
    output logic         o_cmd_en,
    output logic         o_cmd_out,
    input  logic         i_cmd_in,
    output logic         o_rsp_valid,
    output logic [1:0]   o_rsp_status,
    output logic [5:0]   o_rsp_index,
    output logic [119:0] o_rsp_data
);

    localparam int unsigned FRAME_W = 48;
    localparam int unsigned RXSR_W  = 135;
    localparam int unsigned DATA_W  = 120;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NCR_W   = $clog2(NCR + 1);
    localparam int unsigned NCC_W   = $clog2(NCC + 1);

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_R2   = 2'b10;
    localparam logic [1:0] RSP_R3   = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_CRC    = 2'b01;
    localparam logic [1:0] ST_TMO    = 2'b10;
    localparam logic [1:0] ST_NORESP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_GAP
    } state_t;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
        logic fb;
        fb = d ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    // Full command frame {start, transmission, index, arg, crc7, end}.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [5:0] idx,
                                                       input logic [31:0] a);
        logic [39:0] body;
        logic [6:0]  c;
        body = {2'b01, idx, a};
        c    = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, body[i]);
        end
        return {body, c, 1'b1};
    endfunction

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NCR_W-1:0]    ncr_cnt_q, ncr_cnt_d;
    logic [NCC_W-1:0]    ncc_cnt_q, ncc_cnt_d;
    logic [6:0]          crc_q, crc_d;
    logic [RXSR_W-1:0]   rx_sr_q, rx_sr_d;
    logic [1:0]          type_q, type_d;
    logic                en_q, en_d;
    logic                out_q, out_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [1:0]          status_q, status_d;
    logic [5:0]          index_q, index_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [RXSR_W-1:0]   sr_next;
    logic                is_r2;
    logic                crc_en;
    logic                rx_last;
    logic                crc_ok;
    logic [FRAME_W-1:0]  new_frame;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            ncr_cnt_q <= '0;
            ncc_cnt_q <= '0;
            crc_q     <= '0;
            rx_sr_q   <= '0;
            type_q    <= '0;
            en_q      <= 1'b0;
            out_q     <= 1'b1;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            status_q  <= '0;
            index_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            ncr_cnt_q <= ncr_cnt_d;
            ncc_cnt_q <= ncc_cnt_d;
            crc_q     <= crc_d;
            rx_sr_q   <= rx_sr_d;
            type_q    <= type_d;
            en_q      <= en_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            status_q  <= status_d;
            index_q   <= index_d;
            data_q    <= data_d;
        end
    end

    // Next-state, wire sequencing and response assembly.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        ncr_cnt_d = ncr_cnt_q;
        ncc_cnt_d = ncc_cnt_q;
        crc_d     = crc_q;
        rx_sr_d   = rx_sr_q;
        type_d    = type_q;
        en_d      = en_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        status_d  = status_q;
        index_d   = index_q;
        data_d    = data_q;

        new_frame = build_frame(i_cmd, i_arg);
        sr_next   = {rx_sr_q[RXSR_W-2:0], i_cmd_in};
        is_r2     = (type_q == RSP_R2);
        // Bit counter k counts bits after the start bit; R2 skips its 7 header bits.
        crc_en    = is_r2 ? ((bit_cnt_q >= CNT_W'(7)) && (bit_cnt_q <= CNT_W'(126)))
                          : (bit_cnt_q <= CNT_W'(38));
        rx_last   = is_r2 ? (bit_cnt_q == CNT_W'(134)) : (bit_cnt_q == CNT_W'(46));
        crc_ok    = (type_q == RSP_R3) || (crc_q == sr_next[7:1]);

        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    frame_d   = new_frame;
                    out_d     = new_frame[FRAME_W-1];
                    en_d      = 1'b1;
                    bit_cnt_d = '0;
                    type_d    = i_rsp_type;
                    state_d   = S_TX;
                end
            end
            S_TX: begin
                if (i_ce) begin
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        en_d  = 1'b0;
                        out_d = 1'b1;
                        if (type_q == RSP_NONE) begin
                            valid_d   = 1'b1;
                            status_d  = ST_NORESP;
                            index_d   = '0;
                            data_d    = '0;
                            ncc_cnt_d = '0;
                            state_d   = S_GAP;
                        end else begin
                            ncr_cnt_d = '0;
                            state_d   = S_WAIT;
                        end
                    end else begin
                        frame_d   = frame_q << 1;
                        out_d     = frame_q[FRAME_W-2];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (i_ce) begin
                    if (!i_cmd_in) begin
                        bit_cnt_d = '0;
                        crc_d     = '0;
                        rx_sr_d   = '0;
                        state_d   = S_RX;
                    end else if (ncr_cnt_q == NCR_W'(NCR - 1)) begin
                        valid_d   = 1'b1;
                        status_d  = ST_TMO;
                        index_d   = '0;
                        data_d    = '0;
                        ncc_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        ncr_cnt_d = ncr_cnt_q + NCR_W'(1);
                    end
                end
            end
            S_RX: begin
                if (i_ce) begin
                    rx_sr_d = sr_next;
                    if (crc_en) begin
                        crc_d = crc7_step(crc_q, i_cmd_in);
                    end
                    if (rx_last) begin
                        valid_d   = 1'b1;
                        status_d  = (i_cmd_in && crc_ok) ? ST_OK : ST_CRC;
                        index_d   = is_r2 ? 6'h3f : sr_next[45:40];
                        data_d    = is_r2 ? sr_next[127:8] : {88'h0, sr_next[39:8]};
                        ncc_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (i_ce) begin
                    if (ncc_cnt_q == NCC_W'(NCC - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        ncc_cnt_d = ncc_cnt_q + NCC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign o_cmd_ready  = ready_q;
    assign o_cmd_en     = en_q;
    assign o_cmd_out    = out_q;
    assign o_rsp_valid  = valid_q;
    assign o_rsp_status = status_q;
    assign o_rsp_index  = index_q;
    assign o_rsp_data   = data_q;

endmodule

// File: tb/tb_sdhost_cmd.sv
`timescale 1ns/1ps
// Self-checking bench for sdhost_cmd: directed commands with scoreboarded
// transmit frames and responses.
module tb_sdhost_cmd;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   rsp_type = 2'b00;
    logic [5:0]   cmd = 6'd0;
    logic [31:0]  arg = 32'd0;
    logic         cmd_en;
    logic         cmd_out;
    logic         cmd_in = 1'b1;
    logic         rsp_valid;
    logic [1:0]   rsp_status;
    logic [5:0]   rsp_index;
    logic [119:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int ce_div = 1;

    typedef struct {
        logic [1:0]   status;
        logic [5:0]   index;
        logic [119:0] data;
        bit           full;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [47:0] tx_q[$];

    sdhost_cmd #(.NCR(64), .NCC(8)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_ce        (ce),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_rsp_type  (rsp_type),
        .i_cmd       (cmd),
        .i_arg       (arg),
        .o_cmd_en    (cmd_en),
        .o_cmd_out   (cmd_out),
        .i_cmd_in    (cmd_in),
        .o_rsp_valid (rsp_valid),
        .o_rsp_status(rsp_status),
        .o_rsp_index (rsp_index),
        .o_rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    // Tick strobe: one i_ce every ce_div cycles.
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c = (c + 1 >= ce_div) ? 0 : c + 1;
            ce = (c == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [127:0] v, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mkframe(input logic [5:0] idx, input logic [31:0] a);
        logic [39:0] body;
        body = {2'b01, idx, a};
        return {body, crc7({88'h0, body}, 40), 1'b1};
    endfunction

    // Wait for the next clock edge at which i_ce is seen, then step past it.
    task automatic wait_tick();
        @(posedge clk);
        while (!ce) @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [5:0] idx, input logic [31:0] a);
        wait_ready();
        rsp_type  = t;
        cmd       = idx;
        arg       = a;
        cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("accept_en_out", {cmd_en, cmd_out}, 2'b10);
    endtask

    task automatic wait_en_fall();
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_en && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (cmd_en) chk("en_fall_timeout", 1'b1, 1'b0);
    endtask

    task automatic send_rsp(input logic [135:0] bits, input int len, input int delay);
        wait_en_fall();
        cmd_in = 1'b1;
        repeat (delay) wait_tick();
        for (int i = len - 1; i >= 0; i--) begin
            cmd_in = bits[i];
            wait_tick();
        end
        cmd_in = 1'b1;
    endtask

    task automatic push_rsp(input logic [1:0] s, input logic [5:0] idx,
                            input logic [119:0] d, input bit full);
        rsp_t r;
        r.status = s;
        r.index  = idx;
        r.data   = d;
        r.full   = full;
        rsp_q.push_back(r);
    endtask

    // Transmit monitor: captures the pad bit on each tick while driving.
    initial begin
        logic [47:0] cap;
        logic [47:0] exp;
        int          cap_n;
        logic        en_prev;
        cap = '0;
        cap_n = 0;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap_n   = 0;
                en_prev = 1'b0;
            end else begin
                if (en_prev && !cmd_en) begin
                    if (tx_q.size() == 0) begin
                        chk("tx_unexpected", 1'b1, 1'b0);
                    end else begin
                        exp = tx_q.pop_front();
                        chk("tx_frame", cap, exp);
                        chk("tx_len", cap_n, 48);
                    end
                    cap_n = 0;
                end
                if (ce && cmd_en) begin
                    cap = {cap[46:0], cmd_out};
                    cap_n++;
                end
                if (!cmd_en && !cmd_out) chk("idle_out_high", cmd_out, 1'b1);
                en_prev = cmd_en;
            end
        end
    end

    // Response monitor: pops the scoreboard on every completion pulse.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_status", rsp_status, e.status);
                    if (e.full) begin
                        chk("rsp_index", rsp_index, e.index);
                        chk("rsp_data", rsp_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [119:0] payload;
        logic [119:0] flipped;
        logic [6:0]   pcrc;
        int           n;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en_out", {cmd_en, cmd_out}, 2'b01);
        chk("rst_rsp", {rsp_valid, rsp_status, rsp_index}, 9'h0);
        chk("rst_data", rsp_data, 120'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);

        // CMD0, no response: frame, status 11, then an 8-tick gap.
        tx_q.push_back(48'h40_0000_0000_95);
        push_rsp(2'b11, 6'h0, 120'h0, 1'b0);
        issue(2'b00, 6'd0, 32'h0);
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd0_valid_seen", rsp_valid, 1'b1);
        n = 0;
        do begin
            wait_tick();
            n++;
        end while (!cmd_ready && n < 50);
        chk("cmd0_gap_ticks", n, 8);

        // CMD8 R7 as R1; a request during TX must be ignored.
        tx_q.push_back(48'h48_0000_01AA_87);
        push_rsp(2'b00, 6'd8, {88'h0, 32'h0000_01AA}, 1'b1);
        issue(2'b01, 6'd8, 32'h0000_01AA);
        repeat (3) wait_tick();
        cmd = 6'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        send_rsp({88'h0, 48'h08_0000_01AA_13}, 48, 5);
        wait_ready();

        // ACMD41 answered with R3 (CRC field not checked).
        tx_q.push_back(mkframe(6'd41, 32'h40FF_8000));
        push_rsp(2'b00, 6'h3f, {88'h0, 32'h80FF_8000}, 1'b1);
        issue(2'b11, 6'd41, 32'h40FF_8000);
        send_rsp({88'h0, 48'h3F_80FF_8000_FF}, 48, 3);
        wait_ready();

        // R2 with good CRC.
        payload = {$urandom(), $urandom(), $urandom(), $urandom()};
        pcrc    = crc7({8'h0, payload}, 120);
        tx_q.push_back(mkframe(6'd2, 32'h0));
        push_rsp(2'b00, 6'h3f, payload, 1'b1);
        issue(2'b10, 6'd2, 32'h0);
        send_rsp({8'h3f, payload, pcrc, 1'b1}, 136, 2);
        wait_ready();

        // R2 with one payload bit flipped against the original CRC.
        flipped     = payload;
        flipped[57] = ~flipped[57];
        tx_q.push_back(mkframe(6'd2, 32'h0));
        push_rsp(2'b01, 6'h3f, flipped, 1'b1);
        issue(2'b10, 6'd2, 32'h0);
        send_rsp({8'h3f, flipped, pcrc, 1'b1}, 136, 2);
        wait_ready();

        // Timeout at full tick rate, then at quarter rate.
        for (int d = 1; d <= 4; d += 3) begin
            ce_div = d;
            repeat (8) @(posedge clk);
            #2;
            tx_q.push_back(mkframe(6'd17, 32'h0000_1234));
            push_rsp(2'b10, 6'h0, 120'h0, 1'b0);
            issue(2'b01, 6'd17, 32'h0000_1234);
            wait_en_fall();
            n = 0;
            while (!rsp_valid && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", n, 64 * d);
            wait_ready();
        end
        ce_div = 1;
        repeat (4) @(posedge clk);
        #2;

        // Reset mid-TX at bit 20: line released asynchronously, no response.
        issue(2'b00, 6'd0, 32'h0);
        repeat (20) wait_tick();
        chk("bit20_en", cmd_en, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en_out", {cmd_en, cmd_out}, 2'b01);
        repeat (3) @(negedge clk);
        chk("rst_no_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", cmd_ready, 1'b1);
        tx_q.push_back(48'h40_0000_0000_95);
        push_rsp(2'b11, 6'h0, 120'h0, 1'b0);
        issue(2'b00, 6'd0, 32'h0);
        wait_ready();
        repeat (4) @(negedge clk);

        chk("tx_queue_empty", tx_q.size(), 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdhost_cmd.md
# sdhost_cmd

Host-side command-wire engine for the SDIO controller. It serializes 48-bit commands onto the CMD line and captures the card's 48-bit (R1/R3/R6/R7) or 136-bit (R2) response. It generates CRC7 on transmit, checks CRC7 and the end bit on receive, enforces the NCR response timeout, and enforces the NCC gap between commands. It sits between the controller register front-end and the CMD pad, and is the counterpart of the card-side command handler used in simulation.

## Interface
- NCR, 64: SD-clock ticks to wait for a response start bit before timeout.
- NCC, 8: idle SD-clock ticks enforced after each transaction before the next command is accepted.
- i_clk  input  1  system clock; the only clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_ce  input  1  one-cycle strobe marking each SD-clock tick. All wire activity advances only on i_ce.
- i_cmd_valid  input  1  command request.
- o_cmd_ready  output  1  high when the block is IDLE.
- i_rsp_type  input  2  expected response: 00 none, 01 R1 (CRC checked), 10 R2 (136-bit), 11 R3 (CRC not checked).
- i_cmd  input  6  command index.
- i_arg  input  32  command argument.
- o_cmd_en  output  1  pad drive enable.
- o_cmd_out  output  1  pad output data.
- i_cmd_in  input  1  pad input, pre-synchronized and sampled on i_ce.
- o_rsp_valid  output  1  one i_clk pulse per completed transaction.
- o_rsp_status  output  2  00 ok, 01 CRC or end-bit error, 10 timeout, 11 no-response command complete.
- o_rsp_index  output  6  received bits [45:40] (R2: 6'h3f).
- o_rsp_data  output  120  R1/R3: {88'h0, arg[31:0]}; R2: the 120 payload bits, CRC excluded.

## Operation
- States: IDLE, TX, WAIT, RX, GAP.
- IDLE:
  - o_cmd_ready=1.
  - When i_cmd_valid && o_cmd_ready (independent of i_ce), latch the request and build the frame {0,1,i_cmd,i_arg,CRC7,1}. Go to TX.
  - i_cmd_valid while not ready is ignored and never queued.
- CRC7: polynomial x^7+x^3+1, initial value 0.
  - Command: computed over frame bits [47:8].
  - R1 check: over received bits [47:8].
  - R2 check: over the 120 payload bits only; the 8-bit header is excluded.
  - R3: CRC field not checked; the end bit is still checked.
- TX:
  - Shift the frame MSB-first, one bit per i_ce.
  - After 48 bits: type 00 goes to GAP with pending status 11; otherwise go to WAIT.
- WAIT:
  - Each i_ce, sample i_cmd_in. A 0 is the start bit; go to RX.
  - NCR consecutive samples of 1 with no start bit means status 10; go to GAP.
- RX:
  - Shift in the remaining 47 (R1/R3) or 135 (R2) bits, one per i_ce.
  - Status is 01 if the end bit is 0 or the CRC mismatches; otherwise 00. Go to GAP.
- o_rsp_valid: pulses on the i_clk cycle after the final RX bit, the final TX bit (type 00), or the NCR-th WAIT sample. o_rsp_status, o_rsp_index and o_rsp_data are held until the next pulse.
- GAP: count NCC i_ce ticks with the line released, then return to IDLE.
- Reset, including mid-transaction:
  - Asynchronous return to IDLE, with o_cmd_en=0 and o_cmd_out=1 immediately.
  - o_rsp_valid=0, o_rsp_status=0, o_rsp_index=0, o_rsp_data=0.
  - CRC and counters cleared. o_cmd_ready=1 once reset is released.

## Timing
- Accept cycle +1: o_cmd_en=1 and o_cmd_out=start bit 0.
- Bit n (0..47) is held from the cycle after the n-th i_ce following accept until the next i_ce.
- On the i_ce ending bit 47 (end bit 1), o_cmd_en drops on the following cycle. o_cmd_out stays 1 whenever o_cmd_en=0.
- The first WAIT sample is the first i_ce after o_cmd_en drops. The card's two-tick NCR minimum is covered by the line pull-up.
- i_ce held low freezes all counters and shift registers, with outputs stable.
- If i_ce is high every cycle, the minimum R1 transaction is 1 + 48 + ≥1 + 47 + 1 + NCC cycles.
- CRC is accumulated serially; there is no extra latency beyond the o_rsp_valid cycle.

## Test plan
- CMD0, arg 0, type 00:
  - Pad emits 48'h40_0000_0000_95 MSB-first, o_cmd_en high for exactly 48 ticks.
  - o_rsp_valid with status 11; o_cmd_ready returns after 8 more ticks.
- CMD8, arg 0x1AA, type 01:
  - Pad emits 48'h48_0000_01AA_87.
  - Bench replies 48'h08_0000_01AA_13 after 5 ticks; expect status 00, index 8, data[31:0]=0x1AA.
- ACMD41 reply as R3, 48'h3F_80FF_8000_FF: status 00, index 0x3F, data[31:0]=0x80FF8000.
- R2 with random 120-bit payload and correct CRC: status 00, data equals payload. Flipping one payload bit gives status 01.
- Line held high 64 ticks: status 10 exactly one cycle after the 64th sample. With i_ce at 1/4 rate, the same result takes 4× the cycles.
- Assert i_reset_n=0 mid-TX (bit 20):
  - o_cmd_en=0 and o_cmd_out=1 asynchronously, with no o_rsp_valid.
  - After release, a new CMD0 transmits a correct frame.
